regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port between two writeback requesters: wb0 (ALU/execute) and wb1 (load/memory).
- Arbitration is round-robin with valid/ready handshakes.
- Grants go through one registered output stage that drives the register file write port.
- A per-register pending scoreboard is set at issue and cleared at write, so the decode stage gets a read-after-write stall signal for rs1/rs2.

Parameters:
ADDR_W, 3, register address width (matches register file rd/rs1/rs2 width)
DATA_W, 32, register data width
NREGS, 1<<ADDR_W, number of architectural registers; scoreboard width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
wb0_valid  input  1  ALU writeback request
wb0_ready  output  1  wb0 request accepted this cycle
wb0_rd  input  ADDR_W  destination register of wb0
wb0_value  input  DATA_W  write data of wb0
wb1_valid  input  1  load writeback request
wb1_ready  output  1  wb1 request accepted this cycle
wb1_rd  input  ADDR_W  destination register of wb1
wb1_value  input  DATA_W  write data of wb1
mark_en  input  1  issue stage: instruction with destination mark_rd issued
mark_rd  input  ADDR_W  destination to mark pending
rs1  input  ADDR_W  decode source 1
rs2  input  ADDR_W  decode source 2
stall  output  1  decode must hold: a nonzero rs1 or rs2 is pending
busy  output  NREGS  scoreboard pending bits
reg_write_en  output  1  to register file write enable
rd  output  ADDR_W  to register file write address
rd_value  output  DATA_W  to register file write data

Behaviour:
- Reset (async, rst=1): reg_write_en=0, rd=0, rd_value=0, busy=0. Last-grant pointer=1, so wb0 wins the first contested cycle.
- While rst=1: wb0_ready=0, wb1_ready=0, stall=0. Reset mid-transfer discards the output-stage entry; no write is issued.
- Handshake: a transfer occurs when valid&ready are high at a rising edge. ready is combinational from valid and the pointer; it never depends on ready.
- Requesters hold rd/value stable while valid=1 and ready=0.
- Arbitration, one grant per cycle:
  - Only one valid: that requester gets ready=1.
  - Both valid: grant the requester not granted last; pointer updates only on a grant.
  - Neither valid: no grant; pointer unchanged.
- The register file always accepts writes, so the output stage never back-pressures.
- Latency: a grant at edge N drives reg_write_en/rd/rd_value for exactly the cycle after N; the register file commits at edge N+1. Back-to-back grants produce back-to-back writes.
- rd==0 grant: accepted (ready=1), but reg_write_en stays 0 and busy[0] is untouched.
- Scoreboard:
  - mark_en with mark_rd!=0 sets busy[mark_rd] at the edge.
  - An output-stage write (reg_write_en=1) clears busy[rd] at the same edge as the register-file commit.
  - Simultaneous set and clear of the same index: set wins (newer producer).
  - mark_rd==0 is ignored.
  - busy[0] is always 0.
- stall = (rs1!=0 & busy[rs1]) | (rs2!=0 & busy[rs2]). Combinational from registered busy.
- stall stays high during the write cycle and drops the cycle after, when the register file holds the new value. No bypass.
- Double mark of an already-pending register: bit stays set. Ordering of multiple producers to the same register is the pipeline's responsibility; no count is kept.

Decomposition:
- Shared package: ADDR_W/DATA_W defaults, NREGS, and the zero-register index constant, shared with the register file.
- One natural sub-module, wb_rr_arb2: two-input round-robin arbiter with pointer register. Inputs req[1:0]; outputs gnt[1:0].
- Scoreboard and output stage stay in the top.

Test Plan:
- Reset then idle: rst pulse mid-cycle (async) -> all outputs 0 immediately; busy=0, stall=0.
- wb0 alone, rd=5, value=0xDEADBEEF, after mark_rd=5 -> wb0_ready same cycle; next cycle reg_write_en=1, rd=5, rd_value=0xDEADBEEF; busy[5] clears at that edge; rs1=5 stall 1 through write cycle, 0 after.
- wb0 and wb1 both valid 4 cycles, rd=1 and rd=2 -> grants alternate wb0,wb1,wb0,wb1; writes rd=1,2,1,2 on consecutive cycles.
- wb1 rd=0 value=0x1234 -> wb1_ready=1; reg_write_en stays 0; busy unchanged.
- Same-edge mark_rd=3 and write of rd=3 -> busy[3]=1 afterwards; rs2=3 gives stall=1.
- Assert rst while a granted entry is in the output stage -> reg_write_en=0 at once; the write never occurs; pointer back to wb0-first.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg
//   Shared constants for the writeback arbiter and the register file it feeds:
//   default address/data widths, the register count, and the index of the
//   hardwired zero register.
package regfile_wb_arbiter_pkg;

   localparam int ADDR_W_DEF   = 3;
   localparam int DATA_W_DEF   = 32;
   localparam int NREGS_DEF    = 1 << ADDR_W_DEF;
   localparam int REG_ZERO_IDX = 0;

   // Grant vector encodings for the two writeback requesters.
   typedef enum logic [1:0] {
      GNT_NONE = 2'b00,
      GNT_WB0  = 2'b01,
      GNT_WB1  = 2'b10
   } gnt_e;

endpackage

// File: rtl/regfile_wb_arbiter_wb_rr_arb2.sv
// wb_rr_arb2
//   Two-input round-robin arbiter. At most one grant per cycle; when both
//   inputs request, the one not granted last wins. The last-grant pointer
//   only moves when a grant is issued.
//   Ports:
//     clk       clock
//     rst       asynchronous active-high reset (pointer -> wb1, so wb0 wins first)
//     req[1:0]  request vector (bit 0 = wb0, bit 1 = wb1)
//     gnt[1:0]  one-hot grant vector, combinational from req and pointer
module wb_rr_arb2
   import regfile_wb_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   // last_q: 0 = wb0 granted last, 1 = wb1 granted last
   logic last_q;
   logic last_d;

   always_comb begin
      gnt    = GNT_NONE;
      last_d = last_q;
      unique case (req)
         2'b01:   gnt = GNT_WB0;
         2'b10:   gnt = GNT_WB1;
         2'b11:   gnt = last_q ? GNT_WB0 : GNT_WB1;
         default: gnt = GNT_NONE;
      endcase
      if (gnt != GNT_NONE) begin
         last_d = gnt[1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the register file's single write port between the ALU writeback
//   (wb0) and the load writeback (wb1). Granted writes pass through one
//   registered stage that drives the register file. A per-register pending
//   scoreboard (set at issue, cleared at write) produces the decode RAW stall.
//   Ports:
//     clk, rst                      clock, asynchronous active-high reset
//     wb0_valid/ready/rd/value      ALU writeback handshake and payload
//     wb1_valid/ready/rd/value      load writeback handshake and payload
//     mark_en, mark_rd              issue-time pending mark
//     rs1, rs2, stall               decode sources and RAW stall
//     busy                          scoreboard pending bits
//     reg_write_en, rd, rd_value    register file write port
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int NREGS  = 1 << ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb0_valid,
   output logic              wb0_ready,
   input  logic [ADDR_W-1:0] wb0_rd,
   input  logic [DATA_W-1:0] wb0_value,
   input  logic              wb1_valid,
   output logic              wb1_ready,
   input  logic [ADDR_W-1:0] wb1_rd,
   input  logic [DATA_W-1:0] wb1_value,
   input  logic              mark_en,
   input  logic [ADDR_W-1:0] mark_rd,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   output logic              stall,
   output logic [NREGS-1:0]  busy,
   output logic              reg_write_en,
   output logic [ADDR_W-1:0] rd,
   output logic [DATA_W-1:0] rd_value
);

   localparam logic [ADDR_W-1:0] ZERO_RD = ADDR_W'(REG_ZERO_IDX);

   logic [1:0]        req;
   logic [1:0]        gnt;
   logic              wen_q, wen_d;
   logic [ADDR_W-1:0] rd_q, rd_d;
   logic [DATA_W-1:0] val_q, val_d;
   logic [NREGS-1:0]  busy_q, busy_d;

   // Requests are masked during reset so no ready is ever shown while rst=1.
   assign req = {wb1_valid, wb0_valid} & {2{~rst}};

   wb_rr_arb2 u_arb (
      .clk (clk),
      .rst (rst),
      .req (req),
      .gnt (gnt)
   );

   assign wb0_ready = gnt[0];
   assign wb1_ready = gnt[1];

   // Output stage: a grant is always accepted (the register file never
   // back-pressures). Writes to the zero register are swallowed here.
   always_comb begin
      wen_d = 1'b0;
      rd_d  = rd_q;
      val_d = val_q;
      if (gnt[0]) begin
         wen_d = (wb0_rd != ZERO_RD);
         rd_d  = wb0_rd;
         val_d = wb0_value;
      end else if (gnt[1]) begin
         wen_d = (wb1_rd != ZERO_RD);
         rd_d  = wb1_rd;
         val_d = wb1_value;
      end
   end

   // Scoreboard: the clear for a write lands on the same edge the register
   // file commits it. A mark on that edge is a newer producer and wins.
   always_comb begin
      busy_d = busy_q;
      if (wen_q) begin
         busy_d[rd_q] = 1'b0;
      end
      if (mark_en && (mark_rd != ZERO_RD)) begin
         busy_d[mark_rd] = 1'b1;
      end
      busy_d[REG_ZERO_IDX] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wen_q  <= 1'b0;
         rd_q   <= '0;
         val_q  <= '0;
         busy_q <= '0;
      end else begin
         wen_q  <= wen_d;
         rd_q   <= rd_d;
         val_q  <= val_d;
         busy_q <= busy_d;
      end
   end

   assign reg_write_en = wen_q;
   assign rd           = rd_q;
   assign rd_value     = val_q;
   assign busy         = busy_q;

   // No bypass: stall holds through the write cycle and drops once the
   // register file holds the new value.
   assign stall = ~rst & (((rs1 != ZERO_RD) & busy_q[rs1]) |
                          ((rs2 != ZERO_RD) & busy_q[rs2]));

endmodule
